// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, 2-flop row sync,
// per-frame single-key detection and frame-level debounce with a press strobe.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_acc_cnt;
    logic [3:0]       r_acc_code;
    logic             r_cand_valid;
    logic [3:0]       r_cand_code;
    logic [CNT_W-1:0] r_stable_cnt;

    logic             w_tick;
    logic             w_frame_end;
    logic [3:0]       w_low;
    logic [2:0]       w_col_cnt;
    logic [3:0]       w_col_code;
    logic [2:0]       w_sum;
    logic [1:0]       w_sum_sat;
    logic [3:0]       w_sum_code;
    logic             w_res_valid;
    logic             w_same;
    logic [CNT_W-1:0] w_stable_nxt;
    logic             w_commit;
    logic [1:0]       w_col_nxt;

    // Per-column sample decode and frame/debounce next-state
    always_comb begin
        w_tick       = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
        w_frame_end  = w_tick && (r_col_idx == 2'd3);
        w_col_nxt    = r_col_idx + 2'd1;
        w_low        = ~r_row_sync;
        w_col_cnt    = {2'b00, w_low[0]} + {2'b00, w_low[1]}
                     + {2'b00, w_low[2]} + {2'b00, w_low[3]};
        // Row r lives on bit (3-r); lowest row wins inside a column
        w_col_code   = {2'd3, r_col_idx};
        if (w_low[3])      w_col_code = {2'd0, r_col_idx};
        else if (w_low[2]) w_col_code = {2'd1, r_col_idx};
        else if (w_low[1]) w_col_code = {2'd2, r_col_idx};
        w_sum        = {1'b0, r_acc_cnt} + w_col_cnt;
        w_sum_sat    = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
        w_sum_code   = (r_acc_cnt != 2'd0) ? r_acc_code : w_col_code;
        w_res_valid  = (w_sum_sat == 2'd1);
        w_same       = (w_res_valid == r_cand_valid) &&
                       (!w_res_valid || (w_sum_code == r_cand_code));
        w_stable_nxt = CNT_W'(1);
        if (w_same) begin
            w_stable_nxt = (r_stable_cnt == CNT_W'(DEBOUNCE)) ? r_stable_cnt
                                                              : r_stable_cnt + CNT_W'(1);
        end
        w_commit     = w_frame_end && (w_stable_nxt == CNT_W'(DEBOUNCE));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_meta   <= 4'b1111;
            r_row_sync   <= 4'b1111;
            r_div_cnt    <= '0;
            r_col_idx    <= 2'd0;
            r_acc_cnt    <= 2'd0;
            r_acc_code   <= 4'd0;
            r_cand_valid <= 1'b0;
            r_cand_code  <= 4'd0;
            r_stable_cnt <= '0;
            col_n        <= 4'b0111;
            key_code     <= 4'd0;
            key_valid    <= 1'b0;
            key_pulse    <= 1'b0;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;
            key_pulse  <= 1'b0;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_col_idx <= w_col_nxt;
                col_n     <= ~(4'b1000 >> w_col_nxt);
                if (w_frame_end) begin
                    r_acc_cnt    <= 2'd0;
                    r_acc_code   <= 4'd0;
                    r_cand_valid <= w_res_valid;
                    r_cand_code  <= w_sum_code;
                    r_stable_cnt <= w_stable_nxt;
                    if (w_commit) begin
                        key_valid <= w_res_valid;
                        if (w_res_valid) begin
                            key_code  <= w_sum_code;
                            key_pulse <= !(key_valid && (key_code == w_sum_code));
                        end
                    end
                end else begin
                    r_acc_cnt  <= w_sum_sat;
                    r_acc_code <= w_sum_code;
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a press-strobe scoreboard.
module tb_keypad_scanner;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pulse;
    logic [15:0] pressed = 16'h0000;

    int   edge_no = 0;
    int   total   = 0;
    int   bad     = 0;
    exp_t sb[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_pulse (key_pulse)
    );

    always #5 clock = ~clock;

    // Passive matrix: a pressed key shorts its row to its column when that column is driven low
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[3-c]) row_n[3-r] = 1'b0;
    end

    // edge_no = index of the last clock edge since reset released (cycle that edge ended)
    always @(posedge clock) begin
        if (reset) edge_no <= -1;
        else       edge_no <= edge_no + 1;
    end

    // Pulse scoreboard: every strobe must match the oldest expected press
    always @(negedge clock) begin
        if (!reset && key_pulse) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse: observed code=%0d at edge %0d, expected no pulse", key_code, edge_no);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                assert (key_code === e.code) else begin
                    bad++;
                    $error("FAIL pulse_code: observed=%0d expected=%0d", key_code, e.code);
                end
                total++;
                assert (edge_no === e.at) else begin
                    bad++;
                    $error("FAIL pulse_edge: observed=%0d expected=%0d", edge_no, e.at);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        int n = 0;
        while (edge_no != e && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_timeout", 32'(edge_no), 32'(e));
    endtask

    task automatic do_reset(input logic [15:0] keys);
        chk("missed_pulse", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
        pressed = keys;
        reset   = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
    endtask

    function automatic exp_t mk(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        return e;
    endfunction

    initial begin
        // 1: column rotation with no key
        do_reset(16'h0000);
        chk("t1_col_c0",   32'(col_n), 32'h7);
        chk("t1_valid_c0", 32'(key_valid), 32'd0);
        chk("t1_code_c0",  32'(key_code), 32'd0);
        chk("t1_pulse_c0", 32'(key_pulse), 32'd0);
        wait_edge(2);  chk("t1_col_c3",  32'(col_n), 32'h7);
        wait_edge(3);  chk("t1_col_c4",  32'(col_n), 32'hB);
        wait_edge(7);  chk("t1_col_c8",  32'(col_n), 32'hD);
        wait_edge(11); chk("t1_col_c12", 32'(col_n), 32'hE);
        wait_edge(15); chk("t1_col_c16", 32'(col_n), 32'h7);
        wait_edge(63); chk("t1_valid_end", 32'(key_valid), 32'd0);

        // 2: key 6 held from cycle 0, reported at edge 47, single pulse
        do_reset(16'h0040);
        sb.push_back(mk(4'd6, 47));
        wait_edge(46); chk("t2_valid_before", 32'(key_valid), 32'd0);
        wait_edge(47);
        chk("t2_valid", 32'(key_valid), 32'd1);
        chk("t2_code",  32'(key_code), 32'd6);
        chk("t2_pulse", 32'(key_pulse), 32'd1);
        wait_edge(48); chk("t2_pulse_off", 32'(key_pulse), 32'd0);
        wait_edge(111);
        chk("t2_valid_held", 32'(key_valid), 32'd1);
        chk("t2_code_held",  32'(key_code), 32'd6);

        // 3: key 10 on alternate frames never debounces
        do_reset(16'h0400);
        for (int f = 1; f < 8; f++) begin
            wait_edge(16*f - 1);
            pressed = (f % 2 == 0) ? 16'h0400 : 16'h0000;
        end
        wait_edge(143);
        chk("t3_valid", 32'(key_valid), 32'd0);
        chk("t3_code",  32'(key_code), 32'd0);

        // 4: key 0, then 0+5 (multi-key -> none), then only 5
        do_reset(16'h0001);
        sb.push_back(mk(4'd0, 47));
        wait_edge(47);
        chk("t4_valid0", 32'(key_valid), 32'd1);
        chk("t4_code0",  32'(key_code), 32'd0);
        pressed = 16'h0021;
        wait_edge(94); chk("t4_valid_multi_before", 32'(key_valid), 32'd1);
        wait_edge(95);
        chk("t4_valid_multi", 32'(key_valid), 32'd0);
        chk("t4_code_multi",  32'(key_code), 32'd0);
        pressed = 16'h0020;
        sb.push_back(mk(4'd5, 143));
        wait_edge(143);
        chk("t4_valid5", 32'(key_valid), 32'd1);
        chk("t4_code5",  32'(key_code), 32'd5);
        wait_edge(175); chk("t4_valid5_held", 32'(key_valid), 32'd1);

        // 5: key 15 debounced, then released
        do_reset(16'h8000);
        sb.push_back(mk(4'd15, 47));
        wait_edge(47);
        chk("t5_code", 32'(key_code), 32'd15);
        pressed = 16'h0000;
        wait_edge(94); chk("t5_valid_before", 32'(key_valid), 32'd1);
        wait_edge(95);
        chk("t5_valid_rel", 32'(key_valid), 32'd0);
        chk("t5_code_rel",  32'(key_code), 32'd15);
        wait_edge(127); chk("t5_valid_late", 32'(key_valid), 32'd0);

        // 6: reset mid-frame with key 9 held re-debounces with a fresh pulse
        do_reset(16'h0200);
        sb.push_back(mk(4'd9, 47));
        wait_edge(47); chk("t6_code_pre", 32'(key_code), 32'd9);
        wait_edge(55);
        chk("t6_col_mid", 32'(col_n), 32'hD);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_col_rst",   32'(col_n), 32'h7);
        chk("t6_valid_rst", 32'(key_valid), 32'd0);
        chk("t6_code_rst",  32'(key_code), 32'd0);
        sb.push_back(mk(4'd9, 47));
        wait_edge(46); chk("t6_valid_before", 32'(key_valid), 32'd0);
        wait_edge(47);
        chk("t6_valid", 32'(key_valid), 32'd1);
        chk("t6_code",  32'(key_code), 32'd9);
        wait_edge(63);

        chk("final_missed_pulse", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
